// File: rtl/mux2x1_arbiter.sv
// ---------------------------------------------------------------------------
// mux2x1_arbiter
//
// Two-requester round-robin arbiter in front of a 2:1 multiplexer. Two
// agents request the shared output path. The block grants one agent at a
// time, drives the mux select and registers the selected data together with
// a valid flag.
//
// Optional feature (macro MUX2X1_ARB_HOLD_LIMIT_EN):
//   When defined, an owner loses the grant after MAX_HOLD consecutive cycles
//   if the other side is requesting. When undefined, the hold counter is
//   removed and an owner keeps the grant until it drops its request.
//
// Parameters:
//   WIDTH     data width of I0, I1 and y (>= 1)
//   MAX_HOLD  maximum consecutive grant cycles under contention (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req0/req1  requests, held high while the path is needed
//   I0/I1      requester data
//   gnt0/gnt1  registered grants (never both 1)
//   s0         registered mux select (0 -> I0, 1 -> I1)
//   y          registered muxed data
//   y_valid    y carries data from a granted requester
//   state_dbg  current arbiter state (0 idle, 1 own0, 2 own1)
//
// Handshake: reqX is a level request. gntX rises one edge after reqX is
// sampled high and falls on the edge that samples reqX low. Data present
// on the selected input while gntX=1 appears on y, with y_valid=1, one
// edge later.
// ---------------------------------------------------------------------------
module mux2x1_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             s0,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic       r_rr_ptr;
  logic       w_next_rr;
  logic       w_hold_expired;
  logic       w_enter_own;

  // Entry into an ownership state happens only when the state changes to a
  // non-idle state; OWNx -> OWNx is a stay, not an entry.
  assign w_enter_own = (w_next_state != r_state) && (w_next_state != ST_IDLE);

`ifdef MUX2X1_ARB_HOLD_LIMIT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] r_hold_cnt;

  assign w_hold_expired = (r_hold_cnt == CW'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else if (w_enter_own) begin
      r_hold_cnt <= CW'(1);
    end else if ((r_state != ST_IDLE) && !w_hold_expired) begin
      r_hold_cnt <= r_hold_cnt + CW'(1);
    end
  end
`else
  assign w_hold_expired = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_rr    = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (req0 && req1) begin
          w_next_state = r_rr_ptr ? ST_OWN1 : ST_OWN0;
        end else if (req0) begin
          w_next_state = ST_OWN0;
        end else if (req1) begin
          w_next_state = ST_OWN1;
        end
      end
      ST_OWN0: begin
        // A release takes priority over hold expiry; both give the same switch.
        if (!req0) begin
          w_next_rr    = 1'b1;
          w_next_state = req1 ? ST_OWN1 : ST_IDLE;
        end else if (req1 && w_hold_expired) begin
          w_next_rr    = 1'b1;
          w_next_state = ST_OWN1;
        end
      end
      ST_OWN1: begin
        if (!req1) begin
          w_next_rr    = 1'b0;
          w_next_state = req0 ? ST_OWN0 : ST_IDLE;
        end else if (req0 && w_hold_expired) begin
          w_next_rr    = 1'b0;
          w_next_state = ST_OWN0;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      s0       <= 1'b0;
      y        <= '0;
      y_valid  <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_rr_ptr <= w_next_rr;
      gnt0     <= (w_next_state == ST_OWN0);
      gnt1     <= (w_next_state == ST_OWN1);
      // Select only moves on entry to an ownership state; it holds in idle.
      if (w_next_state == ST_OWN0) begin
        s0 <= 1'b0;
      end else if (w_next_state == ST_OWN1) begin
        s0 <= 1'b1;
      end
      // Datapath uses the select and grants as registered before this edge.
      y       <= s0 ? I1 : I0;
      y_valid <= gnt0 | gnt1;
    end
  end

  assign state_dbg = r_state;

endmodule

// File: tb/tb_mux2x1_arbiter.sv
module tb_mux2x1_arbiter;

  localparam int W        = 8;
  localparam int MAX_HOLD = 4;
  localparam int EW       = W + 4;

`ifdef MUX2X1_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [W-1:0] I0 = '0;
  logic [W-1:0] I1 = '0;
  logic         gnt0, gnt1, s0, y_valid;
  logic [W-1:0] y;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  mux2x1_arbiter #(.WIDTH(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .I0(I0), .I1(I1),
    .gnt0(gnt0), .gnt1(gnt1), .s0(s0), .y(y), .y_valid(y_valid),
    .state_dbg(state_dbg)
  );

  // ---------------- reference model ----------------
  // owner: -1 nobody, 0 or 1 the requester holding the path.
  // run:   how many consecutive cycles the current owner has held it.
  int           m_owner = -1;
  int           m_rr    = 0;
  int           m_run   = 0;
  logic         m_s0    = 1'b0;
  logic [W-1:0] m_y     = '0;
  logic         m_yv    = 1'b0;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [EW-1:0] model_edge(input logic r, input logic q0, input logic q1,
                                               input logic [W-1:0] d0, input logic [W-1:0] d1);
    bit mine, other;
    if (r) begin
      m_owner = -1; m_rr = 0; m_run = 0; m_s0 = 1'b0; m_y = '0; m_yv = 1'b0;
    end else begin
      // Output path reflects what was granted before this edge.
      m_y  = m_s0 ? d1 : d0;
      m_yv = (m_owner != -1);
      if (m_owner == -1) begin
        if (q0 && q1) m_owner = m_rr;
        else if (q0)  m_owner = 0;
        else if (q1)  m_owner = 1;
        m_run = 1;
      end else begin
        mine  = (m_owner == 0) ? q0 : q1;
        other = (m_owner == 0) ? q1 : q0;
        if (!mine) begin
          m_rr    = 1 - m_owner;
          m_owner = other ? 1 - m_owner : -1;
          m_run   = 1;
        end else if (HOLD_EN && other && m_run >= MAX_HOLD) begin
          m_owner = 1 - m_owner;
          m_rr    = m_owner;
          m_run   = 1;
        end else begin
          m_run++;
        end
      end
      if (m_owner != -1) m_s0 = (m_owner == 1);
    end
    return {m_owner == 0, m_owner == 1, m_s0, m_yv, m_y};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic q0, input logic q1,
                      input logic [W-1:0] d0, input logic [W-1:0] d1);
    @(negedge clk);
    rst = r; req0 = q0; req1 = q1; I0 = d0; I1 = d1;
    exp_q.push_back(model_edge(r, q0, q1, d0, d1));
  endtask

  task automatic step_rand_data(input logic r, input logic q0, input logic q1);
    step(r, q0, q1, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
  endtask

  // ---------------- monitor / scoreboard ----------------
  always begin
    logic [EW-1:0] exp_v, act_v;
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      act_v = {gnt0, gnt1, s0, y_valid, y};
      n_checks++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL outputs t=%0t {gnt0,gnt1,s0,y_valid,y} got=%b exp=%b", $time, act_v, exp_v);
      n_checks++;
      if ((gnt0 & gnt1) !== 1'b1 && !$isunknown({gnt0, gnt1})) n_pass++;
      else $display("FAIL mutex t=%0t gnt0=%b gnt1=%b exp not both 1", $time, gnt0, gnt1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic q0, q1, r;
    int   waited;

    // Reset with both requests high for two edges.
    step_rand_data(1'b1, 1'b1, 1'b1);
    step_rand_data(1'b1, 1'b1, 1'b1);

    // Single requester 0, then release.
    step(1'b0, 1'b1, 1'b0, 8'h01, 8'hA5);
    step(1'b0, 1'b1, 1'b0, 8'h01, 8'hA5);
    step(1'b0, 1'b1, 1'b0, 8'h3C, 8'hA5);
    step(1'b0, 1'b0, 1'b0, 8'h77, 8'hA5);
    step_rand_data(1'b0, 1'b0, 1'b0);

    // Tie after reset, then requester 0 drops: switch with no bubble.
    step_rand_data(1'b1, 1'b0, 1'b0);
    step_rand_data(1'b0, 1'b1, 1'b1);
    step_rand_data(1'b0, 1'b1, 1'b1);
    step_rand_data(1'b0, 1'b0, 1'b1);
    step_rand_data(1'b0, 1'b0, 1'b1);
    step_rand_data(1'b0, 1'b0, 1'b0);
    step_rand_data(1'b0, 1'b0, 1'b0);

    // Both held 16 cycles from a fresh reset.
    step_rand_data(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step_rand_data(1'b0, 1'b1, 1'b1);
    step_rand_data(1'b0, 1'b0, 1'b0);
    step_rand_data(1'b0, 1'b0, 1'b0);

    // Reset during OWN1, then both held: requester 0 wins the tie.
    step_rand_data(1'b0, 1'b0, 1'b1);
    step_rand_data(1'b0, 1'b0, 1'b1);
    step_rand_data(1'b1, 1'b1, 1'b1);
    step_rand_data(1'b0, 1'b1, 1'b1);
    step_rand_data(1'b0, 1'b1, 1'b1);

    // Random traffic with sticky requests and rare resets.
    q0 = 1'b0; q1 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) q0 = ~q0;
      if ($urandom_range(0, 3) == 0) q1 = ~q1;
      r = ($urandom_range(0, 99) == 0);
      step_rand_data(r, q0, q1);
    end
    step_rand_data(1'b0, 1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d exp 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux2x1_arbiter.md
# mux2x1_arbiter

Two-requester round-robin arbiter wrapping the structural 2:1 multiplexer datapath. It turns the mux select from a free input into a registered, sequenced resource: two agents request the shared output path, the block grants one at a time, drives `s0`, and presents the selected data as a registered output with a valid flag. It sits between the requesting agents and any downstream consumer of the muxed signal.

## Interface
- `WIDTH`, default 1: data width of `I0`, `I1`, `y`. Must be ≥1.
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while the other side is requesting. Must be ≥1. Used only with `MUX2X1_ARB_HOLD_LIMIT_EN`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0` input 1: requester 0 wants the path; held high for as long as it needs it.
- `req1` input 1: requester 1 wants the path.
- `I0` input WIDTH: requester 0 data.
- `I1` input WIDTH: requester 1 data.
- `gnt0` output 1: registered grant to requester 0.
- `gnt1` output 1: registered grant to requester 1.
- `s0` output 1: registered mux select; 0 selects `I0`, 1 selects `I1`.
- `y` output WIDTH: registered muxed data.
- `y_valid` output 1: `y` carries granted data.

## Operation
- State machine states: IDLE, OWN0, OWN1. Internal registers: `rr_ptr`, the preferred requester on a tie, and `hold_cnt`, width $clog2(MAX_HOLD+1).
- Reset: state IDLE; `gnt0`, `gnt1`, `s0`, `y`, `y_valid` all 0; `rr_ptr` 0; `hold_cnt` 0.
- IDLE:
  - Only `req0` high: go to OWN0.
  - Only `req1` high: go to OWN1.
  - Both high: grant `rr_ptr`.
  - Neither high: stay in IDLE.
- Entering OWNx: `gntx`=1, the other grant =0, `s0`=x, `hold_cnt`=1.
- OWNx with `reqx` low (release):
  - `rr_ptr` = other.
  - Other side requesting: go directly to OWNother, no idle bubble.
  - Otherwise: go to IDLE with both grants 0.
- OWNx with `reqx` high:
  - Other side requesting and `hold_cnt`==MAX_HOLD: forced switch to OWNother, `rr_ptr` = other.
  - Otherwise: stay; `hold_cnt` increments, saturating at MAX_HOLD.
- Datapath, every edge:
  - `y` <= `s0` ? `I1` : `I0`.
  - `y_valid` <= `gnt0` | `gnt1`.
  - Both use the current registered `s0` and grants.
- Invariants:
  - `gnt0` & `gnt1` is never 1.
  - `s0` changes only on entry to OWN0 or OWN1.
  - `s0` holds its last value in IDLE.

## Timing
- Request to grant: 1 cycle. A request sampled at edge k gives a grant visible after edge k.
- Grant to data: 1 cycle. Data sampled while `gntx`=1 at edge k+1 appears on `y`, with `y_valid`=1, after edge k+1.
- Release: `reqx` low at edge m drops `gntx` after edge m. `y_valid` drops after edge m+1 unless the other side was granted at edge m.
- Switch with no bubble: the old grant falls and the new grant rises on the same edge. `y_valid` stays 1 continuously.
- Simultaneous release and hold-limit expiry: treated as a release; the outcome is the same switch.
- Reset mid-grant: `rst` high at an edge forces all reset values after that edge, regardless of requests. The first grant after reset goes to requester 0 on a tie.

## Configuration
- `MUX2X1_ARB_HOLD_LIMIT_EN` defined: the MAX_HOLD preemption described above is active.
- Not defined:
  - The `hold_cnt` logic is removed; `MAX_HOLD` is ignored.
  - The owner keeps the grant until it drops its request.
  - Round-robin then applies only to IDLE ties and to releases.

## Test plan
- Reset: `req0`=`req1`=1, `rst`=1 for 2 edges -> `gnt0`=`gnt1`=`s0`=`y`=`y_valid`=0 after each edge.
- Single requester:
  - `req0`=1 with `I0`=1 at edge k -> `gnt0`=1, `s0`=0 after k; `y`=1, `y_valid`=1 after k+1.
  - `req0`=0 at edge m -> `gnt0`=0 after m; `y_valid`=0 after m+1.
- Tie after reset: `req0`=`req1`=1 from IDLE -> `gnt0` first. Drop `req0` -> `gnt1`=1 and `s0`=1 on the same edge that `gnt0` falls; `y_valid` has no gap.
- Hold limit, macro defined, MAX_HOLD=4: both requests held 16 cycles -> grants alternate `gnt0`×4, `gnt1`×4, `gnt0`×4, `gnt1`×4. Without the macro, `gnt0` stays 1 for all 16 cycles.
- Mid-operation reset: `rst`=1 for 1 edge during OWN1 -> all outputs 0 after that edge. With both requests held, `gnt0`=1 after the next edge.
- Mutual exclusion: random `req0`/`req1` for 1000 cycles -> `gnt0`&`gnt1` never 1. `y` always equals the previous cycle's selected input whenever `y_valid`=1.
